alu: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_datapath.sv | 67 ++++++
 rtl/alu.sv | 75 +++++++
 tb/tb_alu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the registered ALU and its combinational datapath.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [2:0] {
    E_ADD = OP_ADD,
    E_SUB = OP_SUB,
    E_AND = OP_AND,
    E_OR  = OP_OR,
    E_XOR = OP_XOR,
    E_SLL = OP_SLL,
    E_SRL = OP_SRL,
    E_SLT = OP_SLT
  } op_e;

endpackage

// File: rtl/alu_datapath.sv
// Purely combinational ALU core: result, carry/borrow, zero and signed set-less-than.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int OPCODE = 3
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [OPCODE-1:0] i_op,
  output logic [WIDTH-1:0]  o_result,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_slt
);

  // WIDTH always fits in WIDTH bits, so the out-of-range test needs no extension.
  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_shift_oob;
  logic           w_less;
  op_e            w_op;

  assign w_sum       = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff      = {1'b0, i_a} - {1'b0, i_b};
  assign w_shift_oob = (i_b >= SHIFT_LIMIT);
  assign w_less      = ($signed(i_a) < $signed(i_b));
  assign w_op        = op_e'(i_op);

  // Operation select; carry and slt default low so only ADD/SUB/SLT drive them.
  always_comb begin
    o_result = {WIDTH{1'b0}};
    o_carry  = 1'b0;
    o_slt    = 1'b0;
    case (w_op)
      E_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      E_SUB: begin
        o_result = w_diff[WIDTH-1:0];
        o_carry  = w_diff[WIDTH];
      end
      E_AND: o_result = i_a & i_b;
      E_OR:  o_result = i_a | i_b;
      E_XOR: o_result = i_a ^ i_b;
      E_SLL: begin
        if (w_shift_oob) o_result = {WIDTH{1'b0}};
        else             o_result = i_a << i_b;
      end
      E_SRL: begin
        if (w_shift_oob) o_result = {WIDTH{1'b0}};
        else             o_result = i_a >> i_b;
      end
      E_SLT: begin
        o_slt    = w_less;
        o_result = {{(WIDTH-1){1'b0}}, w_less};
      end
      default: o_result = {WIDTH{1'b0}};
    endcase
  end

  assign o_zero = (o_result == {WIDTH{1'b0}});

endmodule

// File: rtl/alu.sv
// Registered ALU: one output stage capturing datapath result and flags on valid_data.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int OPCODE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data_in1,
  input  logic [WIDTH-1:0]  data_in2,
  input  logic [OPCODE-1:0] op_code,
  input  logic              valid_data,
  output logic [WIDTH-1:0]  data_out,
  output logic              carry_out,
  output logic              zero_flag,
  output logic              valid_flag,
  output logic              slt_flag
);

  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_zero;
  logic             w_slt;

  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic             r_zero;
  logic             r_valid;
  logic             r_slt;

  alu_datapath #(
    .WIDTH  (WIDTH),
    .OPCODE (OPCODE)
  ) u_datapath (
    .i_a      (data_in1),
    .i_b      (data_in2),
    .i_op     (op_code),
    .o_result (w_result),
    .o_carry  (w_carry),
    .o_zero   (w_zero),
    .o_slt    (w_slt)
  );

  // Output stage: capture on valid, otherwise hold data/flags while valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_slt   <= 1'b0;
    end else begin
      r_valid <= valid_data;
      if (valid_data) begin
        r_data  <= w_result;
        r_carry <= w_carry;
        r_zero  <= w_zero;
        r_slt   <= w_slt;
      end else begin
        r_data  <= r_data;
        r_carry <= r_carry;
        r_zero  <= r_zero;
        r_slt   <= r_slt;
      end
    end
  end

  assign data_out   = r_data;
  assign carry_out  = r_carry;
  assign zero_flag  = r_zero;
  assign valid_flag = r_valid;
  assign slt_flag   = r_slt;

endmodule

// File: tb/tb_alu.sv
// Randomised self-checking bench for alu against an arithmetic reference model.
module tb_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in1;
  logic [W-1:0] data_in2;
  logic [2:0]   op_code;
  logic         valid_data;
  logic [W-1:0] data_out;
  logic         carry_out;
  logic         zero_flag;
  logic         valid_flag;
  logic         slt_flag;

  int errors = 0;
  int checks = 0;

  int exp_data  = 0;
  int exp_carry = 0;
  int exp_zero  = 0;
  int exp_valid = 0;
  int exp_slt   = 0;

  alu #(.WIDTH(W), .OPCODE(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .op_code    (op_code),
    .valid_data (valid_data),
    .data_out   (data_out),
    .carry_out  (carry_out),
    .zero_flag  (zero_flag),
    .valid_flag (valid_flag),
    .slt_flag   (slt_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model computed from the operation rules with plain integers.
  task automatic model(input int op, input int a, input int b,
                       output int res, output int cy, output int slt);
    int sa;
    int sb;
    res = 0; cy = 0; slt = 0;
    case (op)
      0: begin res = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
      1: begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (b >= W) ? 0 : (a * (1 << b)) % 256;
      6: res = (b >= W) ? 0 : a / (1 << b);
      7: begin
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        slt = (sa < sb) ? 1 : 0;
        res = slt;
      end
      default: res = 0;
    endcase
  endtask

  // Model state: updated from the inputs seen at each clock edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    int r, c, s;
    if (!rst_n) begin
      exp_data = 0; exp_carry = 0; exp_zero = 0; exp_valid = 0; exp_slt = 0;
    end else begin
      exp_valid = valid_data ? 1 : 0;
      if (valid_data) begin
        model(int'(op_code), int'(data_in1), int'(data_in2), r, c, s);
        exp_data = r; exp_carry = c; exp_slt = s; exp_zero = (r == 0) ? 1 : 0;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("data_out",   int'(data_out),   exp_data);
    chk("carry_out",  int'(carry_out),  exp_carry);
    chk("zero_flag",  int'(zero_flag),  exp_zero);
    chk("valid_flag", int'(valid_flag), exp_valid);
    chk("slt_flag",   int'(slt_flag),   exp_slt);
  end

  task automatic apply(input int op, input int a, input int b, input bit v);
    @(negedge clk);
    #1;
    op_code    = op[2:0];
    data_in1   = a[W-1:0];
    data_in2   = b[W-1:0];
    valid_data = v;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int op, a, b;
    rst_n = 1'b0; valid_data = 1'b0; op_code = 3'd0; data_in1 = 8'd0; data_in2 = 8'd0;
    #12;
    chk("reset_data", int'(data_out), 0);
    chk("reset_valid", int'(valid_flag), 0);
    @(negedge clk); #1; rst_n = 1'b1;

    apply(0, 255, 255, 1'b0);
    chk("add_novalid_data", int'(data_out), 0);
    chk("add_novalid_vf", int'(valid_flag), 0);
    apply(0, 255, 255, 1'b1);
    chk("add_data", int'(data_out), 254);
    chk("add_carry", int'(carry_out), 1);
    chk("add_zero", int'(zero_flag), 0);
    chk("add_vf", int'(valid_flag), 1);
    apply(1, 40, 50, 1'b1);
    chk("sub_borrow_data", int'(data_out), 246);
    chk("sub_borrow_cy", int'(carry_out), 1);
    apply(1, 50, 40, 1'b1);
    chk("sub_data", int'(data_out), 10);
    chk("sub_cy", int'(carry_out), 0);
    apply(2, 30, 30, 1'b1);
    chk("and_data", int'(data_out), 30);
    apply(3, 0, 0, 1'b0);
    chk("hold_data", int'(data_out), 30);
    chk("hold_vf", int'(valid_flag), 0);
    apply(3, 0, 0, 1'b1);
    chk("or_data", int'(data_out), 0);
    chk("or_zero", int'(zero_flag), 1);
    apply(4, 0, 30, 1'b1);
    chk("xor_data", int'(data_out), 30);
    apply(5, 10, 0, 1'b1);
    chk("sll0_data", int'(data_out), 10);
    apply(5, 1, 7, 1'b1);
    chk("sll7_data", int'(data_out), 128);
    apply(6, 10, 10, 1'b1);
    chk("srl_oob_data", int'(data_out), 0);
    chk("srl_oob_zero", int'(zero_flag), 1);
    apply(7, 10, 10, 1'b1);
    chk("slt_eq_flag", int'(slt_flag), 0);
    chk("slt_eq_data", int'(data_out), 0);
    chk("slt_eq_zero", int'(zero_flag), 1);
    apply(7, 255, 1, 1'b1);
    chk("slt_neg_flag", int'(slt_flag), 1);
    chk("slt_neg_data", int'(data_out), 1);
    apply(0, 100, 27, 1'b1);
    chk("add_pre_rst", int'(data_out), 127);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_vf", int'(valid_flag), 0);
    chk("midrst_zero", int'(zero_flag), 0);
    @(negedge clk); #1; rst_n = 1'b1;
    apply(1, 3, 1, 1'b1);
    chk("post_rst_data", int'(data_out), 2);

    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) a = b;
      apply(op, a, b, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_rst_data", int'(data_out), 0);
        @(negedge clk); #1; rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
